// File: rtl/univ_shiftreg_gray.sv
// Universal WIDTH-bit register: shift, rotate, load and gray-code up/down counting.
// Build option UNIV_SHIFTREG_SATCOUNT_EN makes the gray counter saturate instead of wrapping.
module univ_shiftreg_gray #(
   parameter int unsigned            WIDTH       = 8,
   parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] parallelin,
   input  logic             serialinr,
   input  logic             serialinl,
   output logic [WIDTH-1:0] parallelout,
   output logic             serialoutr,
   output logic             serialoutl,
   output logic [WIDTH-1:0] binout,
   output logic             tc
);

   localparam logic [2:0] MODE_HOLD  = 3'd0;
   localparam logic [2:0] MODE_SHR   = 3'd1;
   localparam logic [2:0] MODE_SHL   = 3'd2;
   localparam logic [2:0] MODE_LOAD  = 3'd3;
   localparam logic [2:0] MODE_ROR   = 3'd4;
   localparam logic [2:0] MODE_ROL   = 3'd5;
   localparam logic [2:0] MODE_GUP   = 3'd6;
   localparam logic [2:0] MODE_GDN   = 3'd7;

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;

   logic [WIDTH-1:0] reg_q;
   logic [WIDTH-1:0] reg_d;
   logic             tc_q;
   logic             tc_d;
   logic [WIDTH-1:0] bin_val;
   logic [WIDTH-1:0] bin_inc;
   logic [WIDTH-1:0] bin_dec;

   // Binary bit i is the XOR of all gray bits at or above i.
   for (genvar i = 0; i < WIDTH; i++) begin : g_gray2bin
      assign bin_val[i] = ^reg_q[WIDTH-1:i];
   end

   assign bin_inc = bin_val + ONE;
   assign bin_dec = bin_val - ONE;

   always_comb begin
      reg_d = reg_q;
      tc_d  = 1'b0;
      case (mode)
         MODE_HOLD: reg_d = reg_q;
         MODE_SHR:  reg_d = {serialinr, reg_q[WIDTH-1:1]};
         MODE_SHL:  reg_d = {reg_q[WIDTH-2:0], serialinl};
         MODE_LOAD: reg_d = parallelin;
         MODE_ROR:  reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
         MODE_ROL:  reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
         MODE_GUP: begin
            tc_d  = (bin_val == ALL_ONES);
            reg_d = bin_inc ^ (bin_inc >> 1);
`ifdef UNIV_SHIFTREG_SATCOUNT_EN
            if (tc_d) reg_d = reg_q;
`endif
         end
         MODE_GDN: begin
            tc_d  = (bin_val == ZERO);
            reg_d = bin_dec ^ (bin_dec >> 1);
`ifdef UNIV_SHIFTREG_SATCOUNT_EN
            if (tc_d) reg_d = reg_q;
`endif
         end
         default: reg_d = reg_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reg_q <= RESET_VALUE;
         tc_q  <= 1'b0;
      end else if (enable) begin
         reg_q <= reg_d;
         tc_q  <= tc_d;
      end
   end

   assign parallelout = reg_q;
   assign serialoutr  = reg_q[0];
   assign serialoutl  = reg_q[WIDTH-1];
   assign binout      = bin_val;
   assign tc          = tc_q;

endmodule

// File: tb/tb_univ_shiftreg_gray.sv
// Directed self-checking bench for univ_shiftreg_gray at WIDTH = 4.
// Expectations follow the UNIV_SHIFTREG_SATCOUNT_EN define when present.
module tb_univ_shiftreg_gray;

   localparam int W = 4;

   logic         clock;
   logic         reset;
   logic         enable;
   logic [2:0]   mode;
   logic [W-1:0] parallelin;
   logic         serialinr;
   logic         serialinl;
   logic [W-1:0] parallelout;
   logic         serialoutr;
   logic         serialoutl;
   logic [W-1:0] binout;
   logic         tc;

   int n_checks = 0;
   int n_fail   = 0;

   univ_shiftreg_gray #(.WIDTH(W), .RESET_VALUE(4'b0000)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .mode        (mode),
      .parallelin  (parallelin),
      .serialinr   (serialinr),
      .serialinl   (serialinl),
      .parallelout (parallelout),
      .serialoutr  (serialoutr),
      .serialoutl  (serialoutl),
      .binout      (binout),
      .tc          (tc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply(input logic [2:0] m, input logic [W-1:0] pin);
      enable     = 1'b1;
      mode       = m;
      parallelin = pin;
      step();
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      mode       = 3'd0;
      parallelin = '0;
      serialinr  = 1'b0;
      serialinl  = 1'b0;
      #12;
      check("rst_reg", parallelout, 4'b0000);
      check("rst_tc", tc, 1'b0);
      check("rst_bin", binout, 4'd0);
      reset = 1'b0;
      step();

      // reset mid-count
      apply(3'd6, '0);
      apply(3'd6, '0);
      apply(3'd6, '0);
      check("cnt3", parallelout, 4'b0010);
      #2 reset = 1'b1;
      #1;
      check("async_rst_reg", parallelout, 4'b0000);
      check("async_rst_tc", tc, 1'b0);
      reset = 1'b0;
      enable = 1'b0;
      mode   = 3'd6;
      step();
      step();
      check("en0_hold", parallelout, 4'b0000);

      // gray up sequence
      apply(3'd6, '0); check("gup1", parallelout, 4'b0001); check("gup1_tc", tc, 1'b0);
      apply(3'd6, '0); check("gup2", parallelout, 4'b0011);
      apply(3'd6, '0); check("gup3", parallelout, 4'b0010);
      apply(3'd6, '0); check("gup4", parallelout, 4'b0110); check("gup4_tc", tc, 1'b0);
      check("gup4_bin", binout, 4'd4);

      // gray down from 4
      apply(3'd7, '0); check("gdn1", parallelout, 4'b0010); check("gdn1_bin", binout, 4'd3);

      // wrap / saturate up
      apply(3'd3, 4'b1000); check("ld1000_bin", binout, 4'd15); check("ld_tc", tc, 1'b0);
      apply(3'd6, '0);
`ifdef UNIV_SHIFTREG_SATCOUNT_EN
      check("wrap_up", parallelout, 4'b1000);
`else
      check("wrap_up", parallelout, 4'b0000);
`endif
      check("wrap_up_tc", tc, 1'b1);
      apply(3'd0, '0);
      check("tc_pulse_end", tc, 1'b0);

      // wrap / saturate down, then tc held while disabled
      apply(3'd3, 4'b0000);
      apply(3'd7, '0);
`ifdef UNIV_SHIFTREG_SATCOUNT_EN
      check("wrap_dn", parallelout, 4'b0000);
`else
      check("wrap_dn", parallelout, 4'b1000);
`endif
      check("wrap_dn_tc", tc, 1'b1);
      enable = 1'b0;
      mode   = 3'd3;
      step();
      check("tc_hold_dis", tc, 1'b1);

      // shifts
      apply(3'd3, 4'b1010);
      serialinr = 1'b1;
      apply(3'd1, '0);
      check("shr", parallelout, 4'b1101);
      check("shr_sor", serialoutr, 1'b1);
      serialinl = 1'b0;
      apply(3'd2, '0);
      check("shl", parallelout, 4'b1010);
      check("shl_sol", serialoutl, 1'b1);
      check("shl_sor", serialoutr, 1'b0);

      // rotates
      apply(3'd3, 4'b0110);
      apply(3'd5, '0); check("rol1", parallelout, 4'b1100);
      apply(3'd5, '0); check("rol2", parallelout, 4'b1001);
      apply(3'd4, '0); check("ror1", parallelout, 4'b1100);
      apply(3'd0, '0); check("hold_mode", parallelout, 4'b1100);

      // enable gating
      apply(3'd3, 4'b0011);
      enable     = 1'b0;
      mode       = 3'd3;
      parallelin = 4'b1111;
      step();
      check("gate_reg", parallelout, 4'b0011);
      check("gate_tc", tc, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
